// File: rtl/tx_retry_ctrl_pkg.sv
// Shared types and widths for the TX retry controller.
// State encoding, timer/exponent/retry widths and small arithmetic helpers.
package tx_retry_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_GRANT = 2'd1,
    ST_TX         = 2'd2,
    ST_WAIT_ACK   = 2'd3
  } state_t;

  localparam int ACK_TMR_W = 9;
  localparam int EXP_W     = 4;
  localparam int RETRY_W   = 4;

  // SIFS + slot + preamble/SIG; the widest sum (127+31+127) still fits 9 bits.
  function automatic logic [ACK_TMR_W-1:0] ack_wait_us(input logic [6:0] sifs,
                                                       input logic [4:0] slot,
                                                       input logic [6:0] pre);
    return ACK_TMR_W'(sifs) + ACK_TMR_W'(slot) + ACK_TMR_W'(pre);
  endfunction

  function automatic logic [EXP_W-1:0] cw_step(input logic [EXP_W-1:0] cur,
                                               input logic [EXP_W-1:0] max_exp);
    logic [EXP_W:0] inc;
    inc = {1'b0, cur} + 1'b1;
    return (inc > {1'b0, max_exp}) ? max_exp : inc[EXP_W-1:0];
  endfunction

endpackage

// File: rtl/tx_retry_ctrl_us_down_timer.sv
// Microsecond down-counter: load has priority, decrements on tick while nonzero.
// Latency: zero flag follows the count register combinationally.
module us_down_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    zero = (cnt == '0);
  end

endmodule

// File: rtl/tx_retry_ctrl.sv
// Frame TX sequencer: waits for the CSMA grant, launches TX, awaits ACK, retries with CW growth.
// Strobes are registered: tx_start one cycle after the grant, tx_done one cycle after the deciding event.
module tx_retry_ctrl
  import tx_retry_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               tsf_pulse_1M,
  input  logic               tx_req,
  input  logic               tx_need_ack,
  input  logic [RETRY_W-1:0] tx_max_retry,
  input  logic [EXP_W-1:0]   cw_min_exp,
  input  logic [EXP_W-1:0]   cw_max_exp,
  input  logic               high_tx_allowed,
  input  logic               tx_end_strobe,
  input  logic               ack_rx_strobe,
  input  logic [6:0]         sifs_time,
  input  logic [4:0]         slot_time,
  input  logic [6:0]         preamble_sig_time,
  output logic               tx_start,
  output logic [EXP_W-1:0]   cw_exp,
  output logic [RETRY_W-1:0] retry_count,
  output logic               retry_flag,
  output logic               busy,
  output logic               tx_done_strobe,
  output logic               tx_success,
  output logic               tx_fail
);

  state_t               state, state_nxt;
  logic                 need_ack_q;
  logic [RETRY_W-1:0]   max_retry_q;
  logic [RETRY_W-1:0]   retry_q;
  logic [EXP_W-1:0]     cw_q;
  logic                 start_q, done_q, success_q, fail_q;

  logic                 ev_accept, ev_grant, ev_ok, ev_fail, ev_retry, tmr_load;
  logic [ACK_TMR_W-1:0] tmr_cnt;
  logic                 tmr_zero;

  us_down_timer #(.W(ACK_TMR_W)) u_ack_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (ack_wait_us(sifs_time, slot_time, preamble_sig_time)),
    .tick     (tsf_pulse_1M && (state == ST_WAIT_ACK)),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ev_accept = 1'b0;
    ev_grant  = 1'b0;
    ev_ok     = 1'b0;
    ev_fail   = 1'b0;
    ev_retry  = 1'b0;
    tmr_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx_req) begin
          ev_accept = 1'b1;
          state_nxt = ST_WAIT_GRANT;
        end
      end
      ST_WAIT_GRANT: begin
        if (high_tx_allowed) begin
          ev_grant  = 1'b1;
          state_nxt = ST_TX;
        end
      end
      ST_TX: begin
        if (tx_end_strobe) begin
          if (need_ack_q) begin
            tmr_load  = 1'b1;
            state_nxt = ST_WAIT_ACK;
          end else begin
            ev_ok     = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_WAIT_ACK: begin
        // An ACK landing on the expiry cycle still counts as success.
        if (ack_rx_strobe) begin
          ev_ok     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tmr_zero) begin
          if (retry_q == max_retry_q) begin
            ev_fail   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            ev_retry  = 1'b1;
            state_nxt = ST_WAIT_GRANT;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      need_ack_q  <= 1'b0;
      max_retry_q <= '0;
      retry_q     <= '0;
      cw_q        <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      success_q   <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      start_q   <= ev_grant;
      done_q    <= ev_ok | ev_fail;
      success_q <= ev_ok;
      fail_q    <= ev_fail;
      if (ev_accept) begin
        need_ack_q  <= tx_need_ack;
        max_retry_q <= tx_max_retry;
        retry_q     <= '0;
        cw_q        <= cw_min_exp;
      end
      if ((ev_ok && (state == ST_WAIT_ACK)) || ev_fail) begin
        cw_q <= cw_min_exp;
      end
      if (ev_retry) begin
        retry_q <= (retry_q == '1) ? retry_q : retry_q + 1'b1;
        cw_q    <= cw_step(cw_q, cw_max_exp);
      end
    end
  end

  always_comb begin
    tx_start       = start_q;
    tx_done_strobe = done_q;
    tx_success     = success_q;
    tx_fail        = fail_q;
    cw_exp         = cw_q;
    retry_count    = retry_q;
    retry_flag     = (retry_q != '0);
    busy           = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_tx_retry_ctrl.sv
// Directed bench for tx_retry_ctrl with hand-computed expectations.
module tb_tx_retry_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       tsf_pulse_1M, tx_req, tx_need_ack, high_tx_allowed, tx_end_strobe, ack_rx_strobe;
  logic [3:0] tx_max_retry, cw_min_exp, cw_max_exp;
  logic [6:0] sifs_time, preamble_sig_time;
  logic [4:0] slot_time;
  logic       tx_start, retry_flag, busy, tx_done_strobe, tx_success, tx_fail;
  logic [3:0] cw_exp, retry_count;

  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int base;

  tx_retry_ctrl dut (
    .clk(clk), .rst(rst), .tsf_pulse_1M(tsf_pulse_1M), .tx_req(tx_req),
    .tx_need_ack(tx_need_ack), .tx_max_retry(tx_max_retry),
    .cw_min_exp(cw_min_exp), .cw_max_exp(cw_max_exp),
    .high_tx_allowed(high_tx_allowed), .tx_end_strobe(tx_end_strobe),
    .ack_rx_strobe(ack_rx_strobe), .sifs_time(sifs_time), .slot_time(slot_time),
    .preamble_sig_time(preamble_sig_time), .tx_start(tx_start), .cw_exp(cw_exp),
    .retry_count(retry_count), .retry_flag(retry_flag), .busy(busy),
    .tx_done_strobe(tx_done_strobe), .tx_success(tx_success), .tx_fail(tx_fail)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_start)       start_cnt++;
    if (tx_done_strobe) done_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic need, input logic [3:0] mx);
    tx_req = 1'b1; tx_need_ack = need; tx_max_retry = mx;
    step();
    tx_req = 1'b0; tx_need_ack = 1'b0; tx_max_retry = 4'd0;
  endtask

  task automatic do_grant();
    high_tx_allowed = 1'b1;
    step();
    high_tx_allowed = 1'b0;
    step();
  endtask

  task automatic do_end();
    tx_end_strobe = 1'b1;
    step();
    tx_end_strobe = 1'b0;
  endtask

  task automatic tick_us(input int n);
    for (int i = 0; i < n; i++) begin
      tsf_pulse_1M = 1'b1;
      step();
      tsf_pulse_1M = 1'b0;
      step();
    end
  endtask

  initial begin
    rst = 1'b1; tsf_pulse_1M = 1'b0; tx_req = 1'b0; tx_need_ack = 1'b0;
    tx_max_retry = 4'd0; high_tx_allowed = 1'b0; tx_end_strobe = 1'b0; ack_rx_strobe = 1'b0;
    cw_min_exp = 4'd4; cw_max_exp = 4'd5;
    sifs_time = 7'd16; slot_time = 5'd9; preamble_sig_time = 7'd20;
    repeat (2) step();
    check("rst_start", tx_start, 0);
    check("rst_done", tx_done_strobe, 0);
    check("rst_succ", tx_success, 0);
    check("rst_fail", tx_fail, 0);
    check("rst_busy", busy, 0);
    check("rst_rflag", retry_flag, 0);
    check("rst_retry", retry_count, 0);
    check("rst_cw", cw_exp, 0);
    rst = 1'b0;
    step();

    // No-ACK frame
    do_req(1'b0, 4'd3);
    check("t1_busy", busy, 1);
    check("t1_cw", cw_exp, 4);
    check("t1_start_early", tx_start, 0);
    high_tx_allowed = 1'b1;
    step();
    high_tx_allowed = 1'b0;
    check("t1_start_lat", tx_start, 1);
    step();
    check("t1_start_pulse", tx_start, 0);
    do_end();
    check("t1_done", tx_done_strobe, 1);
    check("t1_succ", tx_success, 1);
    check("t1_fail", tx_fail, 0);
    check("t1_retry", retry_count, 0);
    check("t1_idle", busy, 0);
    step();
    check("t1_done_pulse", tx_done_strobe, 0);

    // ACK after 30 us of a 45 us window
    do_req(1'b1, 4'd3);
    do_grant();
    do_end();
    check("t2_wait", busy, 1);
    check("t2_nodone", tx_done_strobe, 0);
    tick_us(30);
    check("t2_still", busy, 1);
    ack_rx_strobe = 1'b1;
    step();
    ack_rx_strobe = 1'b0;
    check("t2_done", tx_done_strobe, 1);
    check("t2_succ", tx_success, 1);
    check("t2_fail", tx_fail, 0);
    check("t2_cw", cw_exp, 4);
    check("t2_retry", retry_count, 0);

    // No ACK, two retries then failure
    base = start_cnt;
    do_req(1'b1, 4'd2);
    check("t3_cw0", cw_exp, 4);
    do_grant(); do_end(); tick_us(45);
    check("t3_r1_busy", busy, 1);
    check("t3_r1_done", tx_done_strobe, 0);
    check("t3_r1_cnt", retry_count, 1);
    check("t3_r1_cw", cw_exp, 5);
    do_grant(); do_end(); tick_us(45);
    check("t3_r2_cnt", retry_count, 2);
    check("t3_r2_cw", cw_exp, 5);
    check("t3_r2_flag", retry_flag, 1);
    do_grant(); do_end(); tick_us(44);
    check("t3_pre_done", tx_done_strobe, 0);
    check("t3_pre_cnt", retry_count, 2);
    check("t3_pre_flag", retry_flag, 1);
    tick_us(1);
    check("t3_done", tx_done_strobe, 1);
    check("t3_fail", tx_fail, 1);
    check("t3_succ", tx_success, 0);
    check("t3_cw_end", cw_exp, 4);
    check("t3_cnt_end", retry_count, 2);
    check("t3_starts", 16'(start_cnt - base), 3);
    check("t3_idle", busy, 0);

    // ACK coincides with expiry; max_retry 0 would otherwise fail
    do_req(1'b1, 4'd0);
    do_grant(); do_end(); tick_us(44);
    tsf_pulse_1M = 1'b1;
    step();
    tsf_pulse_1M = 1'b0;
    ack_rx_strobe = 1'b1;
    step();
    ack_rx_strobe = 1'b0;
    check("t4_done", tx_done_strobe, 1);
    check("t4_succ", tx_success, 1);
    check("t4_fail", tx_fail, 0);
    check("t4_retry", retry_count, 0);

    // Strobes in the wrong states
    step();
    ack_rx_strobe = 1'b1; tx_end_strobe = 1'b1; high_tx_allowed = 1'b1;
    step();
    ack_rx_strobe = 1'b0; tx_end_strobe = 1'b0; high_tx_allowed = 1'b0;
    check("t5_idle_busy", busy, 0);
    check("t5_idle_start", tx_start, 0);
    check("t5_idle_done", tx_done_strobe, 0);
    do_req(1'b0, 4'd7);
    tx_req = 1'b1; tx_need_ack = 1'b1; tx_end_strobe = 1'b1; ack_rx_strobe = 1'b1;
    step();
    tx_req = 1'b0; tx_need_ack = 1'b0; tx_end_strobe = 1'b0; ack_rx_strobe = 1'b0;
    check("t5_wg_busy", busy, 1);
    check("t5_wg_start", tx_start, 0);
    check("t5_wg_done", tx_done_strobe, 0);
    do_grant();
    high_tx_allowed = 1'b1; ack_rx_strobe = 1'b1; tx_req = 1'b1;
    step();
    high_tx_allowed = 1'b0; ack_rx_strobe = 1'b0; tx_req = 1'b0;
    check("t5_tx_start", tx_start, 0);
    check("t5_tx_done", tx_done_strobe, 0);
    do_end();
    check("t5_done", tx_done_strobe, 1);
    check("t5_succ", tx_success, 1);

    // Reset while waiting for an ACK on a retried frame
    step();
    do_req(1'b1, 4'd3);
    do_grant(); do_end(); tick_us(45);
    check("t6_retry1", retry_count, 1);
    do_grant(); do_end(); tick_us(5);
    base = done_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_done", tx_done_strobe, 0);
    check("t6_retry", retry_count, 0);
    check("t6_flag", retry_flag, 0);
    check("t6_cw", cw_exp, 0);
    check("t6_start", tx_start, 0);
    tick_us(60);
    check("t6_nodone", 16'(done_cnt - base), 0);
    check("t6_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/tx_retry_ctrl.md
TX_RETRY_CTRL -- requirements
Module: tx_retry_ctrl

Interface
REQ-001 SHALL have `clk`, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-002 SHALL have `rst`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have `tsf_pulse_1M`, input, 1 bit: 1 µs tick, high for one `clk` cycle.
REQ-004 SHALL have `tx_req`, input, 1 bit: one-cycle pulse meaning a frame is queued for transmission.
REQ-005 SHALL have `tx_need_ack`, input, 1 bit: frame expects an ACK; sampled on an accepted `tx_req`.
REQ-006 SHALL have `tx_max_retry`, input, 4 bits: retry limit, sampled on an accepted `tx_req`.
REQ-007 SHALL have `cw_min_exp` and `cw_max_exp`, input, 4 bits each: contention-window exponent bounds, with `cw_min_exp` <= `cw_max_exp`.
REQ-008 SHALL have `high_tx_allowed`, input, 1 bit: backoff-done grant from the CSMA/CA block.
REQ-009 SHALL have `tx_end_strobe`, input, 1 bit: one-cycle pulse from the PHY meaning the last sample has been sent.
REQ-010 SHALL have `ack_rx_strobe`, input, 1 bit: one-cycle pulse meaning a valid-FCS ACK addressed to us was received.
REQ-011 SHALL have `sifs_time` (input, 7 bits), `slot_time` (input, 5 bits) and `preamble_sig_time` (input, 7 bits), all in µs.
REQ-012 SHALL have `tx_start`, output, 1 bit: one-cycle pulse that launches PHY TX.
REQ-013 SHALL have `cw_exp`, output, 4 bits: current CW exponent, fed to CSMA/CA.
REQ-014 SHALL have `retry_count`, output, 4 bits: retries used so far for the current frame.
REQ-015 SHALL have `retry_flag`, output, 1 bit: high when `retry_count` != 0, used for the FC retry bit.
REQ-016 SHALL have `busy`, output, 1 bit: high in any state other than IDLE.
REQ-017 SHALL have `tx_done_strobe` (output, 1 bit), `tx_success` (output, 1 bit) and `tx_fail` (output, 1 bit); `tx_success` and `tx_fail` are valid only while `tx_done_strobe` is high.

Function
REQ-018 SHALL implement states IDLE, WAIT_GRANT, TX, WAIT_ACK.
REQ-019 In IDLE, `tx_req` SHALL move to WAIT_GRANT; latch `tx_need_ack` and `tx_max_retry`; clear `retry_count`; set `cw_exp` to `cw_min_exp`.
REQ-020 `tx_req` SHALL be ignored while `busy` is high; there is no queueing.
REQ-021 In WAIT_GRANT, `high_tx_allowed` SHALL assert `tx_start` in the next cycle and enter TX; the latency from grant to `tx_start` is exactly 1 cycle.
REQ-022 In TX with latched need_ack=0, `tx_end_strobe` SHALL produce `tx_done_strobe`=1 and `tx_success`=1 in the next cycle and return to IDLE.
REQ-023 In TX with latched need_ack=1, `tx_end_strobe` SHALL load a 9-bit ACK timer with `sifs_time` + `slot_time` + `preamble_sig_time` (zero-extended, no overflow, maximum 285) and enter WAIT_ACK.
REQ-024 In WAIT_ACK, the ACK timer SHALL decrement on each `tsf_pulse_1M` while nonzero.
REQ-025 In WAIT_ACK, `ack_rx_strobe` SHALL give success, reset `cw_exp` to `cw_min_exp`, and enter IDLE.
REQ-026 In WAIT_ACK, timer==0 without `ack_rx_strobe` is a timeout.
  - If `retry_count` == latched max: `tx_fail`=1, `cw_exp` := `cw_min_exp`, enter IDLE.
  - Otherwise: `retry_count`+1, `cw_exp` := min(`cw_exp`+1, `cw_max_exp`), enter WAIT_GRANT.
REQ-027 When `ack_rx_strobe` and timeout coincide in the same cycle, the ACK SHALL win.
REQ-028 `ack_rx_strobe` outside WAIT_ACK SHALL be ignored.
REQ-029 `tx_end_strobe` outside TX SHALL be ignored.
REQ-030 `high_tx_allowed` outside WAIT_GRANT SHALL be ignored.
REQ-031 `tx_start` and `tx_done_strobe` SHALL each be one-cycle pulses.
REQ-032 `tx_success` and `tx_fail` SHALL never both be 1.
REQ-033 `retry_count` SHALL saturate at 15 and never wrap.
REQ-034 `cw_exp` SHALL never exceed `cw_max_exp`.

Reset
REQ-035 With `rst`=1 at a `clk` edge, the following SHALL hold the next cycle:
  - state = IDLE, ACK timer = 0;
  - `tx_start` = `tx_done_strobe` = `tx_success` = `tx_fail` = `busy` = `retry_flag` = 0;
  - `retry_count` = 0, `cw_exp` = 0.
REQ-036 Reset asserted mid-frame (any state) SHALL abandon the frame without emitting `tx_done_strobe`.

Structure
REQ-037 A shared package SHALL hold the state encoding (2 bits), the ACK timer width (9), and the exponent/retry widths (4).
REQ-038 One sub-module, `us_down_timer`, SHALL be used for the ACK timer: load, decrement on `tsf_pulse_1M`, zero flag.

Verification
REQ-039 need_ack=0: `tx_req` -> grant -> `tx_start` 1 cycle after the grant; `tx_end_strobe` -> `tx_done_strobe`=1, `tx_success`=1, `retry_count`=0.
REQ-040 sifs=16, slot=9, preamble=20, need_ack=1, ACK at 30 µs after `tx_end_strobe` -> success, `cw_exp`=`cw_min_exp`=4.
REQ-041 No ACK, max_retry=2, `cw_min_exp`=4, `cw_max_exp`=5 -> timeout at 45 µs.
  - `cw_exp` sequence: 4, 5, 5.
  - Three `tx_start` pulses.
  - Final `tx_fail`=1 with `retry_count`=2 and `retry_flag`=1 before done.
REQ-042 `ack_rx_strobe` in the same cycle as the timer reaching 0 -> `tx_success`=1, no retry.
REQ-043 `tx_req`, `ack_rx_strobe` and `tx_end_strobe` applied in the wrong states -> no state change.
REQ-044 `rst` pulse in WAIT_ACK -> IDLE, no `tx_done_strobe`, all outputs 0.
